// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

   localparam int ADDR_W        = 32;
   localparam int MEM_CODE_W    = 2;
   localparam int PCTRL_STATE_W = 3;

   typedef enum logic [MEM_CODE_W-1:0] {
      MEM_CODE_DONE  = 2'd0,
      MEM_CODE_WAIT  = 2'd1,
      MEM_CODE_FAULT = 2'd2
   } mem_code_e;

   typedef enum logic [PCTRL_STATE_W-1:0] {
      PCTRL_RUN      = 3'd0,
      PCTRL_MEM_WAIT = 3'd1,
      PCTRL_DRAIN    = 3'd2,
      PCTRL_HALTED   = 3'd3,
      PCTRL_FAULT    = 3'd4
   } pctrl_state_e;

   // True when a memory op is outstanding and reports the given response code.
   function automatic logic mem_hit(input logic vld, input logic [MEM_CODE_W-1:0] code,
                                    input mem_code_e want);
      return vld && (code == want);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/branch/memory inputs and stall/flush/status outputs of the sequencer.
interface pipeline_ctrl_if #(
   parameter int NUM_STAGES = 5,
   parameter int CNT_W      = 32
);
   import pipeline_ctrl_pkg::*;

   logic                    i_hazard;
   logic                    i_branch;
   logic [ADDR_W-1:0]       i_branch_addr;
   logic                    i_mem_req_valid;
   logic [MEM_CODE_W-1:0]   i_mem_res_code;
   logic                    i_retire;
   logic                    i_halt_req;
   logic [NUM_STAGES-1:0]   o_stall;
   logic [NUM_STAGES-1:0]   o_flush;
   logic                    o_fe_branch;
   logic [ADDR_W-1:0]       o_fe_branch_addr;
   logic [PCTRL_STATE_W-1:0] o_state;
   logic                    o_halted;
   logic                    o_fault;
   logic [CNT_W-1:0]        o_cyc_cnt;
   logic [CNT_W-1:0]        o_ret_cnt;
   logic [CNT_W-1:0]        o_stall_cnt;

   modport master (
      output i_hazard, i_branch, i_branch_addr, i_mem_req_valid, i_mem_res_code,
             i_retire, i_halt_req,
      input  o_stall, o_flush, o_fe_branch, o_fe_branch_addr, o_state, o_halted,
             o_fault, o_cyc_cnt, o_ret_cnt, o_stall_cnt
   );

   modport slave (
      input  i_hazard, i_branch, i_branch_addr, i_mem_req_valid, i_mem_res_code,
             i_retire, i_halt_req,
      output o_stall, o_flush, o_fe_branch, o_fe_branch_addr, o_state, o_halted,
             o_fault, o_cyc_cnt, o_ret_cnt, o_stall_cnt
   );

endinterface

// File: rtl/pipeline_ctrl_perf_counter.sv
// Free-running wrap-around event counter with synchronous clear.
module pipeline_ctrl_perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] count_q;

   // Count one event per cycle; wraps modulo 2^CNT_W.
   always_ff @(posedge clk) begin
      if (clr) begin
         count_q <= '0;
      end else if (i_inc) begin
         count_q <= count_q + CNT_W'(1);
      end else begin
         count_q <= count_q;
      end
   end

   assign o_count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: hazards, branches, memory waits, debug drain and faults.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int NUM_STAGES   = 5,
   parameter int BRANCH_STAGE = 2,
   parameter int MEM_TIMEOUT  = 15,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             clr,
   pipeline_ctrl_if.slave   bus
);

   pctrl_state_e          state_q;
   logic [7:0]            wait_cnt_q;
   logic [7:0]            drain_cnt_q;
   logic                  wait_from_drain_q;
   logic                  halted_q;
   logic                  fault_q;

   logic [NUM_STAGES-1:0] stall_d;
   logic [NUM_STAGES-1:0] flush_d;
   logic                  fe_branch_d;
   logic [ADDR_W-1:0]     fe_addr_d;
   logic                  mem_wait_d;
   logic                  mem_fault_d;
   logic                  in_drain_d;

   assign mem_wait_d  = mem_hit(bus.i_mem_req_valid, bus.i_mem_res_code, MEM_CODE_WAIT);
   assign mem_fault_d = mem_hit(bus.i_mem_req_valid, bus.i_mem_res_code, MEM_CODE_FAULT);
   assign in_drain_d  = (state_q == PCTRL_DRAIN);

   // Sequencer FSM with wait/drain counters and registered status flags.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q           <= PCTRL_RUN;
         wait_cnt_q        <= 8'd0;
         drain_cnt_q       <= 8'd0;
         wait_from_drain_q <= 1'b0;
         halted_q          <= 1'b0;
         fault_q           <= 1'b0;
      end else begin
         case (state_q)
            PCTRL_RUN: begin
               if (mem_fault_d) begin
                  state_q <= PCTRL_FAULT;
                  fault_q <= 1'b1;
               end else if (mem_wait_d) begin
                  state_q           <= PCTRL_MEM_WAIT;
                  wait_cnt_q        <= 8'd1;
                  wait_from_drain_q <= 1'b0;
               end else if (bus.i_halt_req) begin
                  state_q     <= PCTRL_DRAIN;
                  drain_cnt_q <= 8'd0;
               end else begin
                  state_q <= PCTRL_RUN;
               end
            end
            PCTRL_MEM_WAIT: begin
               if (bus.i_mem_res_code == MEM_CODE_DONE) begin
                  state_q <= wait_from_drain_q ? PCTRL_DRAIN : PCTRL_RUN;
               end else if ((bus.i_mem_res_code == MEM_CODE_FAULT) ||
                            ((bus.i_mem_res_code == MEM_CODE_WAIT) &&
                             (wait_cnt_q == 8'(MEM_TIMEOUT)))) begin
                  state_q <= PCTRL_FAULT;
                  fault_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            PCTRL_DRAIN: begin
               if (mem_fault_d) begin
                  state_q <= PCTRL_FAULT;
                  fault_q <= 1'b1;
               end else if (mem_wait_d) begin
                  state_q           <= PCTRL_MEM_WAIT;
                  wait_cnt_q        <= 8'd1;
                  wait_from_drain_q <= 1'b1;
               end else if (drain_cnt_q == 8'(NUM_STAGES - 2)) begin
                  // The next increment reaches NUM_STAGES-1: every stage has emptied.
                  state_q  <= PCTRL_HALTED;
                  halted_q <= 1'b1;
               end else begin
                  drain_cnt_q <= drain_cnt_q + 8'd1;
               end
            end
            PCTRL_HALTED: begin
               if (!bus.i_halt_req) begin
                  state_q  <= PCTRL_RUN;
                  halted_q <= 1'b0;
               end else begin
                  state_q <= PCTRL_HALTED;
               end
            end
            PCTRL_FAULT: begin
               state_q <= PCTRL_FAULT;
            end
            default: begin
               state_q <= PCTRL_RUN;
            end
         endcase
      end
   end

   // Per-stage stall/flush vectors and FE redirect, zero-cycle from state and inputs.
   always_comb begin
      stall_d     = '0;
      flush_d     = '0;
      fe_branch_d = 1'b0;
      fe_addr_d   = '0;
      if (clr) begin
         flush_d = '1;
      end else begin
         case (state_q)
            PCTRL_RUN, PCTRL_DRAIN: begin
               // While draining, FE fetches nothing new.
               stall_d[0] = in_drain_d;
               flush_d[0] = in_drain_d;
               if (mem_fault_d || mem_wait_d) begin
                  // The older memory op wins; branch/hazard are re-presented later.
                  stall_d = '1;
               end else if (bus.i_branch) begin
                  // A same-cycle hazard belongs to an instruction being flushed anyway.
                  flush_d[BRANCH_STAGE-1:0] = '1;
                  fe_branch_d               = !in_drain_d;
                  fe_addr_d                 = in_drain_d ? '0 : bus.i_branch_addr;
               end else if (bus.i_hazard) begin
                  stall_d[BRANCH_STAGE-1:0] = '1;
                  flush_d[BRANCH_STAGE-1]   = 1'b1;
               end else begin
                  fe_branch_d = 1'b0;
               end
            end
            PCTRL_MEM_WAIT, PCTRL_HALTED, PCTRL_FAULT: begin
               stall_d = '1;
            end
            default: begin
               stall_d = '1;
            end
         endcase
      end
   end

   assign bus.o_stall          = stall_d;
   assign bus.o_flush          = flush_d;
   assign bus.o_fe_branch      = fe_branch_d;
   assign bus.o_fe_branch_addr = fe_addr_d;
   assign bus.o_state          = state_q;
   assign bus.o_halted         = halted_q;
   assign bus.o_fault          = fault_q;

   pipeline_ctrl_perf_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
      .clk     (clk),
      .clr     (clr),
      .i_inc   (!clr),
      .o_count (bus.o_cyc_cnt)
   );

   pipeline_ctrl_perf_counter #(.CNT_W(CNT_W)) u_ret_cnt (
      .clk     (clk),
      .clr     (clr),
      .i_inc   (bus.i_retire && !stall_d[NUM_STAGES-1]),
      .o_count (bus.o_ret_cnt)
   );

   pipeline_ctrl_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .clr     (clr),
      .i_inc   (stall_d[0]),
      .o_count (bus.o_stall_cnt)
   );

endmodule
